// File: rtl/half_softmax_sum_if.sv
// Handshake bundle between the exp2 stage, half_softmax_sum and the normalising divider.
// Input side: fire-and-forget in_valid/a with in_ready and sticky overflow status.
// Output side: out_valid/out_ready stream carrying out_data, out_sum and out_last.
interface half_softmax_sum_if;
    logic        in_valid;
    logic [15:0] a;
    logic        in_ready;
    logic        overflow;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [15:0] out_sum;
    logic        out_last;

    // Upstream/downstream environment view.
    modport master (
        output in_valid, a, out_ready,
        input  in_ready, overflow, out_valid, out_data, out_sum, out_last
    );

    // Block view.
    modport slave (
        input  in_valid, a, out_ready,
        output in_ready, overflow, out_valid, out_data, out_sum, out_last
    );
endinterface

// File: rtl/half_softmax_sum.sv
// half_add: IEEE half-precision adder, round-to-nearest-even, inf/NaN propagation.
// Latency 2 cycles from in_valid to out_valid, fully pipelined.
// No backpressure; every in_valid produces exactly one out_valid.
// Ports: clk, rst_n (async active-low), in_valid, a, b -> out_valid, c.
module half_add (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    output logic [15:0] c
);
    logic        a_nan, b_nan, a_inf, b_inf;
    logic [15:0] x, y;          // x carries the larger magnitude
    logic [5:0]  ex, ey, d, e;
    logic [3:0]  dcl;
    logic [10:0] mx, my;
    logic [27:0] al;
    logic [13:0] my_al;
    logic [14:0] s;
    logic        rnd;
    logic [11:0] m;
    logic [15:0] res;

    always_comb begin
        a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
        b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
        a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
        b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);

        // For finite halves the magnitude bits order the same way as the values.
        x = (a[14:0] >= b[14:0]) ? a : b;
        y = (a[14:0] >= b[14:0]) ? b : a;

        // Subnormals use exponent 1 with no hidden bit.
        ex = (x[14:10] == 5'd0) ? 6'd1 : {1'b0, x[14:10]};
        ey = (y[14:10] == 5'd0) ? 6'd1 : {1'b0, y[14:10]};
        mx = {x[14:10] != 5'd0, x[9:0]};
        my = {y[14:10] != 5'd0, y[9:0]};

        // Align the smaller operand; three extra bits are guard/round/sticky.
        d     = ex - ey;
        dcl   = (d > 6'd14) ? 4'd14 : d[3:0];
        al    = {my, 3'b000, 14'd0} >> dcl;
        my_al = {al[27:15], al[14] | (|al[13:0])};

        if (x[15] ^ y[15])
            s = {1'b0, mx, 3'b000} - {1'b0, my_al};
        else
            s = {1'b0, mx, 3'b000} + {1'b0, my_al};

        e = ex;
        if (s[14]) begin
            s = {1'b0, s[14:2], s[1] | s[0]};
            e = e + 6'd1;
        end
        // Left-normalise after cancellation, stopping at the subnormal exponent.
        for (int i = 0; i < 13; i++) begin
            if (!s[13] && (e > 6'd1)) begin
                s = s << 1;
                e = e - 6'd1;
            end
        end

        rnd = s[2] & (s[1] | s[0] | s[3]);
        m   = {1'b0, s[13:3]} + {11'd0, rnd};
        if (m[11]) begin
            m = {1'b0, m[11:1]};
            e = e + 6'd1;
        end

        if (a_nan || b_nan)
            res = 16'h7E00;
        else if (a_inf && b_inf)
            res = (a[15] != b[15]) ? 16'h7E00 : a;
        else if (a_inf)
            res = a;
        else if (b_inf)
            res = b;
        else if (s == 15'd0)
            res = {a[15] & b[15], 15'd0};   // exact cancellation gives +0 unless both are -0
        else if (e >= 6'd31)
            res = {x[15], 5'h1F, 10'd0};
        else
            res = {x[15], m[10] ? e[4:0] : 5'd0, m[9:0]};
    end

    logic        v1, v2;
    logic [15:0] r1, r2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            r1 <= 16'h0000;
            r2 <= 16'h0000;
        end else begin
            v1 <= in_valid;
            r1 <= res;
            v2 <= v1;
            r2 <= r1;
        end
    end

    assign out_valid = v2;
    assign c         = r2;
endmodule

// half_softmax_sum: buffers VEC_LEN half exp results, sums them serially with half_add,
// then streams each buffered value paired with the vector sum.
// Latency: VEC_LEN*(1+L_add) cycles of summation after the last accept, then one beat per cycle.
// Backpressure: none on input (drops set sticky overflow); output held stable while out_ready=0.
// Ports: clk, rst (async active-high), bus (half_softmax_sum_if.slave).
module half_softmax_sum #(
    parameter int VEC_LEN = 16,
    parameter int IDX_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    half_softmax_sum_if.slave  bus
);
    if (VEC_LEN < 2 || (1 << IDX_W) < VEC_LEN) begin : g_param_check
        $error("half_softmax_sum: bad VEC_LEN/IDX_W");
    end

    localparam logic [IDX_W-1:0] LAST = IDX_W'(VEC_LEN - 1);

    typedef enum logic [1:0] {FILL, ISSUE, WAIT, DRAIN} state_t;

    state_t           state;
    logic [15:0]      vec_buf [VEC_LEN];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] nxt_rd;
    logic [15:0]      acc;

    logic             add_in_vld;
    logic             add_out_vld;
    logic [15:0]      add_b;
    logic [15:0]      add_c;

    assign nxt_rd     = rd_idx + 1'b1;
    assign add_in_vld = (state == ISSUE);
    assign add_b      = vec_buf[rd_idx];

    // Reset also clears the adder pipeline so no stale result can reach acc.
    half_add u_add (
        .clk       (clk),
        .rst_n     (~rst),
        .in_valid  (add_in_vld),
        .a         (acc),
        .b         (add_b),
        .out_valid (add_out_vld),
        .c         (add_c)
    );

    // Element storage needs no reset: it is always written before it is read.
    always_ff @(posedge clk) begin
        if (state == FILL && bus.in_valid)
            vec_buf[wr_idx] <= bus.a;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= FILL;
            wr_idx        <= '0;
            rd_idx        <= '0;
            acc           <= 16'h0000;
            bus.in_ready  <= 1'b1;
            bus.overflow  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_data  <= 16'h0000;
            bus.out_sum   <= 16'h0000;
        end else begin
            // Anything arriving outside FILL is dropped and flagged.
            if (bus.in_valid && state != FILL)
                bus.overflow <= 1'b1;

            case (state)
                FILL: begin
                    if (bus.in_valid) begin
                        if (wr_idx == LAST) begin
                            wr_idx       <= '0;
                            rd_idx       <= '0;
                            acc          <= 16'h0000;
                            bus.in_ready <= 1'b0;
                            state        <= ISSUE;
                        end else begin
                            wr_idx <= wr_idx + 1'b1;
                        end
                    end
                end

                ISSUE: state <= WAIT;

                WAIT: begin
                    if (add_out_vld) begin
                        acc <= add_c;
                        if (rd_idx == LAST) begin
                            // Pre-load the first beat so outputs come straight from flops.
                            rd_idx        <= '0;
                            bus.out_valid <= 1'b1;
                            bus.out_data  <= vec_buf[0];
                            bus.out_sum   <= add_c;
                            bus.out_last  <= 1'b0;
                            state         <= DRAIN;
                        end else begin
                            rd_idx <= nxt_rd;
                            state  <= ISSUE;
                        end
                    end
                end

                DRAIN: begin
                    if (bus.out_ready) begin
                        if (rd_idx == LAST) begin
                            rd_idx        <= '0;
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                            bus.in_ready  <= 1'b1;
                            state         <= FILL;
                        end else begin
                            rd_idx       <= nxt_rd;
                            bus.out_data <= vec_buf[nxt_rd];
                            bus.out_last <= (nxt_rd == LAST);
                        end
                    end
                end

                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_half_softmax_sum.sv
module tb_half_softmax_sum;
    localparam int VL = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    half_softmax_sum_if bus();

    half_softmax_sum #(.VEC_LEN(VL), .IDX_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] d;
        logic [15:0] s;
        logic        l;
    } beat_t;

    beat_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    int    rdy_mode = 0;

    // ---------------- reference arithmetic on reals ----------------
    function automatic real p2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        int ex = int'(h[14:10]);
        int fr = int'(h[9:0]);
        if (ex == 0) return real'(fr) * p2(-24);
        return real'(fr + 1024) * p2(ex - 25);
    endfunction

    function automatic int rne(input real y);
        int  f  = $rtoi(y);
        real fr = y - real'(f);
        if (fr > 0.5) f = f + 1;
        else if (fr == 0.5 && (f % 2) == 1) f = f + 1;
        return f;
    endfunction

    // Nearest-even rounding of a non-negative real to half.
    function automatic logic [15:0] r2h(input real x);
        int e;
        int m;
        if (x >= 65520.0) return 16'h7C00;
        if (x < p2(-14)) begin
            m = rne(x * p2(24));
            return 16'(m);
        end
        e = -14;
        while (x >= p2(e + 1)) e = e + 1;
        m = rne(x * p2(10 - e));
        if (m == 2048) begin
            m = 1024;
            e = e + 1;
        end
        if (e > 15) return 16'h7C00;
        return {1'b0, 5'(e + 15), 10'(m - 1024)};
    endfunction

    function automatic logic [15:0] hadd(input logic [15:0] x, input logic [15:0] y);
        if (x[14:10] == 5'h1F || y[14:10] == 5'h1F) return 16'h7C00;
        return r2h(h2r(x) + h2r(y));
    endfunction

    function automatic logic [15:0] model_sum(input logic [15:0] v [VL]);
        logic [15:0] s = 16'h0000;
        for (int i = 0; i < VL; i++) s = hadd(s, v[i]);
        return s;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake, checks stall stability
    // and the cycle after the last beat.
    logic [15:0] held_d, held_s;
    logic        held = 1'b0;
    logic        post_last = 1'b0;
    beat_t       eb;

    always @(negedge clk) begin
        if (rst) begin
            held      = 1'b0;
            post_last = 1'b0;
        end else begin
            if (post_last) begin
                check("post_last_out_valid", 16'(bus.out_valid), 16'h0);
                check("post_last_in_ready", 16'(bus.in_ready), 16'h1);
                post_last = 1'b0;
            end
            if (held) begin
                check("stall_data", bus.out_data, held_d);
                check("stall_sum", bus.out_sum, held_s);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got data %h with no beat expected", bus.out_data);
                end else begin
                    eb = exp_q.pop_front();
                    check("beat_data", bus.out_data, eb.d);
                    check("beat_sum", bus.out_sum, eb.s);
                    check("beat_last", 16'(bus.out_last), 16'(eb.l));
                    if (eb.l) post_last = 1'b1;
                end
                held = 1'b0;
            end else if (bus.out_valid) begin
                held   = 1'b1;
                held_d = bus.out_data;
                held_s = bus.out_sum;
            end else begin
                held = 1'b0;
            end
        end
    end

    // Downstream ready driver: 0 always-1, 1 pattern 1,0,0, 2 random, 3 stalled.
    initial begin
        int ph = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (ph % 3 == 0);
                2:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
            ph++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_vec(input logic [15:0] v [VL], input int gap_max, input bit expect_out);
        logic [15:0] s;
        beat_t       b;
        s = model_sum(v);
        if (expect_out) begin
            for (int i = 0; i < VL; i++) begin
                b.d = v[i];
                b.s = s;
                b.l = (i == VL - 1);
                exp_q.push_back(b);
            end
        end
        for (int i = 0; i < VL; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk);
                #1;
            end
            bus.in_valid = 1'b1;
            bus.a        = v[i];
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || bus.out_valid || !bus.in_ready) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (n >= 500) begin
            bad++;
            $display("FAIL %s: drain timeout, %0d beats still expected", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #400000;
        total++;
        bad++;
        $display("FAIL watchdog: simulation did not complete");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic [15:0] v [VL];
        int          n;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 16'(bus.out_valid), 16'h0);
        check("rst_overflow", 16'(bus.overflow), 16'h0);
        check("rst_out_data", bus.out_data, 16'h0000);
        check("rst_out_sum", bus.out_sum, 16'h0000);
        check("rst_out_last", 16'(bus.out_last), 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 16'(bus.in_ready), 16'h1);
        @(posedge clk);
        #1;

        // Basic vector, always ready.
        rdy_mode = 0;
        v = '{16'h3C00, 16'h4000, 16'h4400, 16'h4800};
        send_vec(v, 0, 1);
        check("in_ready_fall", 16'(bus.in_ready), 16'h0);
        wait_drain("basic");

        // Same vector with stalls.
        rdy_mode = 1;
        send_vec(v, 0, 1);
        wait_drain("stall");
        rdy_mode = 0;

        // Two vectors back to back: acc must restart from zero.
        v = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
        send_vec(v, 0, 1);
        wait_drain("vec_a");
        v = '{16'h3800, 16'h3800, 16'h3800, 16'h3800};
        send_vec(v, 0, 1);
        wait_drain("vec_b");

        // Infinity passes through both data and sum.
        v = '{16'h7C00, 16'h3C00, 16'h3C00, 16'h3C00};
        send_vec(v, 0, 1);
        wait_drain("inf");

        // Overflow pulse while summing.
        v = '{16'h4200, 16'h3A00, 16'h4500, 16'h3C00};
        send_vec(v, 0, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.a        = 16'h5555;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("overflow_set", 16'(bus.overflow), 16'h1);
        wait_drain("overflow");
        check("overflow_sticky", 16'(bus.overflow), 16'h1);

        // Reset during the second WAIT.
        v = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
        send_vec(v, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_wait_acc", dut.acc, 16'h0000);
        check("rst_wait_out_valid", 16'(bus.out_valid), 16'h0);
        check("rst_wait_overflow", 16'(bus.overflow), 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_wait_in_ready", 16'(bus.in_ready), 16'h1);
        @(posedge clk);
        #1;
        send_vec(v, 0, 1);
        wait_drain("after_rst_wait");

        // Reset mid-DRAIN drops out_valid asynchronously.
        rdy_mode = 3;
        v = '{16'h3400, 16'h3800, 16'h3C00, 16'h4000};
        send_vec(v, 0, 1);
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (n >= 200) begin
            bad++;
            $display("FAIL drain_wait: out_valid never rose");
        end
        #1;
        rst = 1'b1;
        #1;
        check("rst_drain_out_valid", 16'(bus.out_valid), 16'h0);
        check("rst_drain_out_sum", bus.out_sum, 16'h0000);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send_vec(v, 0, 1);
        wait_drain("after_rst_drain");

        // Randomised vectors with input gaps and random backpressure.
        rdy_mode = 2;
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < VL; i++) begin
                if (k % 2 == 0) v[i] = 16'($urandom_range(16'h3000, 16'h4600));
                else            v[i] = 16'($urandom_range(0, 16'h7BFF));
            end
            send_vec(v, 2, 1);
            wait_drain("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
